// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with single-line refill
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module instruction_cache #(
  parameter int NUM_LINES = 4,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [31:0]          req_addr,
  output logic                 hit,
  output logic [31:0]          instruction,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ready,
  input  logic [LINE_BITS-1:0] mem_data,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_BITS-1:0] data_arr [NUM_LINES];

  logic [IDX-1:0]       req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [1:0]           word_sel;
  logic [IDX-1:0]       fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic [LINE_BITS-1:0] sel_line;
  logic                 miss;
  logic                 unused_byte_offset;

  assign req_idx  = req_addr[3+IDX:4];
  assign req_tag  = req_addr[31:4+IDX];
  assign word_sel = req_addr[3:2];
  assign fill_idx = mem_addr[3+IDX:4];
  assign fill_tag = mem_addr[31:4+IDX];
  assign sel_line = data_arr[req_idx];
  assign unused_byte_offset = ^req_addr[1:0];

  assign hit         = req_valid && (state == IDLE) && valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign instruction = hit ? sel_line[{word_sel, 5'b00000} +: 32] : 32'h0;
  assign miss        = req_valid && (state == IDLE) && !hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state    <= FILL;
            mem_req  <= 1'b1;
            mem_addr <= {req_addr[31:4], 4'b0000};
          end
        end
        FILL: begin
          // The refill completes against the latched address; fetch redirects do not retarget it.
          if (mem_ready) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            valid[fill_idx] <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state == FILL) && mem_ready) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'h1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'h1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - self-checking bench for instruction_cache
// Counter expectations follow ICACHE_STATS_EN as seen by this compilation.
module tb_instruction_cache;

  localparam int NUM_LINES = 4;
  localparam int LINE_BITS = 128;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic [31:0]          req_addr;
  logic                 hit;
  logic [31:0]          instruction;
  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic                 mem_ready;
  logic [LINE_BITS-1:0] mem_data;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  int checks = 0;
  int errors = 0;

  instruction_cache #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .hit(hit), .instruction(instruction), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 rst;
    logic                 rv;
    logic [31:0]          addr;
    logic                 rdy;
    logic [LINE_BITS-1:0] data;
    logic                 exp_hit;
    logic [31:0]          exp_instr;
    logic                 exp_req;
    logic [31:0]          exp_maddr;
    logic [31:0]          exp_hits;
    logic [31:0]          exp_misses;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef ICACHE_STATS_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  // Reference memory image: every word is a fixed function of its own address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [LINE_BITS-1:0] line_of(input logic [31:0] b);
    return {word_of(b + 32'd12), word_of(b + 32'd8), word_of(b + 32'd4), word_of(b)};
  endfunction

  task automatic apply(input logic r, input logic v, input logic [31:0] a, input logic rd,
                       input logic [LINE_BITS-1:0] d);
    @(negedge clk);
    reset = r; req_valid = v; req_addr = a; mem_ready = rd; mem_data = d;
    #1;
  endtask

  localparam logic [127:0] D = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
  localparam logic [127:0] E = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] F = {4{32'hF0F0_0200}};
  localparam logic [127:0] G = 128'h0000_0003_0000_0002_0000_0001_3000_0000;
  localparam logic [127:0] H = 128'h8888_0003_8888_0002_8888_0001_8888_0000;
  localparam logic [127:0] K = 128'h5555_0003_5555_0002_5555_0001_5555_0000;

  bit          ref_present [NUM_LINES];
  logic [27:0] ref_line    [NUM_LINES];
  bit          filling;
  logic [31:0] fill_addr;
  logic [31:0] nhit, nmiss;

  initial begin
    int lat;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; mem_ready = 1'b0; mem_data = '0;
    repeat (2) @(negedge clk);

    //             rst rv addr          rdy data  hit instr          req maddr         hits misses
    tbl.push_back('{0, 0, 32'h0,        0, 128'h0, 0, 32'h0,         0, 32'h0,         0, 0});
    tbl.push_back('{0, 1, 32'h104,      0, 128'h0, 0, 32'h0,         0, 32'h0,         0, 0});
    tbl.push_back('{0, 1, 32'h104,      0, 128'h0, 0, 32'h0,         1, 32'h100,       0, 1});
    tbl.push_back('{0, 1, 32'h104,      0, 128'h0, 0, 32'h0,         1, 32'h100,       0, 1});
    tbl.push_back('{0, 1, 32'h104,      1, D,      0, 32'h0,         1, 32'h100,       0, 1});
    tbl.push_back('{0, 1, 32'h104,      0, 128'h0, 1, 32'hBBBB_BBBB, 0, 32'h100,       0, 1});
    tbl.push_back('{0, 1, 32'h100,      0, 128'h0, 1, 32'hAAAA_AAAA, 0, 32'h100,       1, 1});
    tbl.push_back('{0, 1, 32'h108,      0, 128'h0, 1, 32'hCCCC_CCCC, 0, 32'h100,       2, 1});
    tbl.push_back('{0, 1, 32'h10C,      0, 128'h0, 1, 32'hDDDD_DDDD, 0, 32'h100,       3, 1});
    tbl.push_back('{0, 1, 32'h104,      0, 128'h0, 1, 32'hBBBB_BBBB, 0, 32'h100,       4, 1});
    tbl.push_back('{0, 1, 32'h140,      0, 128'h0, 0, 32'h0,         0, 32'h100,       5, 1});
    tbl.push_back('{0, 1, 32'h140,      1, E,      0, 32'h0,         1, 32'h140,       5, 2});
    tbl.push_back('{0, 1, 32'h140,      0, 128'h0, 1, 32'h1111_1111, 0, 32'h140,       5, 2});
    tbl.push_back('{0, 1, 32'h100,      0, 128'h0, 0, 32'h0,         0, 32'h140,       6, 2});
    tbl.push_back('{0, 0, 32'h0,        1, D,      0, 32'h0,         1, 32'h100,       6, 3});
    tbl.push_back('{0, 1, 32'h200,      0, 128'h0, 0, 32'h0,         0, 32'h100,       6, 3});
    tbl.push_back('{0, 1, 32'h300,      0, 128'h0, 0, 32'h0,         1, 32'h200,       6, 4});
    tbl.push_back('{0, 1, 32'h300,      1, F,      0, 32'h0,         1, 32'h200,       6, 4});
    tbl.push_back('{0, 1, 32'h300,      0, 128'h0, 0, 32'h0,         0, 32'h200,       6, 4});
    tbl.push_back('{0, 1, 32'h300,      1, G,      0, 32'h0,         1, 32'h300,       6, 5});
    tbl.push_back('{0, 1, 32'h300,      0, 128'h0, 1, 32'h3000_0000, 0, 32'h300,       6, 5});
    tbl.push_back('{0, 1, 32'h400,      0, 128'h0, 0, 32'h0,         0, 32'h300,       7, 5});
    tbl.push_back('{1, 1, 32'h400,      1, H,      0, 32'h0,         1, 32'h400,       7, 6});
    tbl.push_back('{0, 1, 32'h400,      0, 128'h0, 0, 32'h0,         0, 32'h0,         0, 0});
    tbl.push_back('{0, 1, 32'h100,      1, H,      0, 32'h0,         1, 32'h400,       0, 1});
    tbl.push_back('{0, 1, 32'h404,      0, 128'h0, 1, 32'h8888_0001, 0, 32'h400,       0, 1});
    tbl.push_back('{0, 1, 32'h404,      1, E,      1, 32'h8888_0001, 0, 32'h400,       1, 1});
    tbl.push_back('{0, 1, 32'h408,      0, 128'h0, 1, 32'h8888_0002, 0, 32'h400,       2, 1});

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].rv, tbl[i].addr, tbl[i].rdy, tbl[i].data);
      check($sformatf("row%0d hit", i), {31'b0, hit}, {31'b0, tbl[i].exp_hit});
      check($sformatf("row%0d instruction", i), instruction, tbl[i].exp_instr);
      check($sformatf("row%0d mem_req", i), {31'b0, mem_req}, {31'b0, tbl[i].exp_req});
      check($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].exp_maddr);
      check($sformatf("row%0d hit_count", i), hit_count, stat_exp(tbl[i].exp_hits));
      check($sformatf("row%0d miss_count", i), miss_count, stat_exp(tbl[i].exp_misses));
    end

    // Miss penalty: memory answers in the 5th cycle of mem_req, so the line hits 6 cycles after the miss.
    apply(1, 0, 32'h0, 0, '0);
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      apply(0, 1, 32'h54, (k == 5), K);
      if (hit) begin
        lat = k;
        check("penalty instruction", instruction, 32'h5555_0001);
      end
    end
    check("penalty cycles", 32'(lat), 32'd6);

    apply(1, 0, 32'h0, 0, '0);
    for (int i = 0; i < NUM_LINES; i++) ref_present[i] = 1'b0;
    filling = 1'b0; fill_addr = 32'h0; nhit = 32'h0; nmiss = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      logic        r, v, rd, eh;
      logic [31:0] a, q;
      int          idx;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 8);
      rd = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | (32'($urandom_range(0, 11)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      apply(r, v, a, rd, line_of(fill_addr));
      q   = a >> 4;
      idx = int'(q % 32'(NUM_LINES));
      eh  = v && !filling && ref_present[idx] && (ref_line[idx] == a[31:4]);
      check("rand hit", {31'b0, hit}, {31'b0, eh});
      check("rand instruction", instruction, eh ? word_of(a) : 32'h0);
      check("rand mem_req", {31'b0, mem_req}, {31'b0, filling});
      check("rand mem_addr", mem_addr, fill_addr);
      check("rand hit_count", hit_count, stat_exp(nhit));
      check("rand miss_count", miss_count, stat_exp(nmiss));
      if (r) begin
        for (int i = 0; i < NUM_LINES; i++) ref_present[i] = 1'b0;
        filling = 1'b0; fill_addr = 32'h0; nhit = 32'h0; nmiss = 32'h0;
      end else begin
        if (eh) nhit = nhit + 32'h1;
        if (filling) begin
          if (rd) begin
            q = fill_addr >> 4;
            ref_present[int'(q % 32'(NUM_LINES))] = 1'b1;
            ref_line[int'(q % 32'(NUM_LINES))]    = fill_addr[31:4];
            filling = 1'b0;
          end
        end else if (v && !eh) begin
          filling   = 1'b1;
          fill_addr = {a[31:4], 4'b0000};
          nmiss     = nmiss + 32'h1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
